radix4_seq_divider: RTL
=======================

Name: radix4_seq_divider

Overview:
- Sequential unsigned integer divider; the inverse path of the team's combinational 8x8 decoder-based multiplier.
- Retires 2 quotient bits per clock, mirroring the multiplier's 2-bit operand grouping.
- Each step selects from precomputed divisor multiples 0, D, 2D and 3D.
- Used to recover operands and check products in the arithmetic datapath.
- Start/busy/done handshake; one result per command.

Parameters:
- DW, 16, dividend and quotient width; must be even and at least 2.
- VW, 8, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- dividend  input  DW  unsigned dividend; captured on accepted start.
- divisor  input  VW  unsigned divisor; captured on accepted start.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  set with done when the captured divisor is 0.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; all internal registers cleared.
- Reset mid-operation: the operation is abandoned, outputs return to reset values, and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - Capture dividend and divisor.
  - Precompute D, 2D, 3D (VW+2 bits).
  - Clear partial remainder R (VW+2 bits).
  - Load step counter = DW/2.
  - busy=1 after edge N. Go to RUN, or to DONE if divisor==0.
  - done and div_by_zero clear; quotient and remainder hold until overwritten.
- RUN, each edge:
  - T = {R[VW-1:0], next 2 MSBs of the shifted dividend}.
  - Digit q = largest k in {3,2,1,0} with k*D <= T.
  - R = T - q*D.
  - Shift q into the quotient shift register LSB side.
  - Decrement the counter.
  - After DW/2 edges (edges N+1..N+DW/2), go to DONE.
  - Invariant: R < D always, so R fits in VW bits.
- DONE (one cycle):
  - done=1, busy=0.
  - quotient and remainder are driven from the final registers.
  - Next edge returns to IDLE, done=0; the results remain stable until the next accepted start.
- Latency: done is high in the cycle after edge N+DW/2 (N+8 at defaults), i.e. 8 cycles of busy.
- Divide by zero:
  - Transition IDLE->DONE directly at edge N; done and div_by_zero are high after edge N.
  - quotient = all ones; remainder = dividend[VW-1:0].
  - div_by_zero clears at the next accepted start.
- start while busy or in DONE: ignored, with no effect on operands or the operation in flight.
- start held high continuously: a new command is accepted in each IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
- A zero dividend follows the normal path: quotient=0, remainder=0 after the full latency.
- Compare arithmetic is VW+2 bits wide with no truncation; 3D for D=255 is 765 and fits in 10 bits.

Test Plan:
- dividend=50000, divisor=200, start one cycle -> busy for 8 cycles, then done pulse: quotient=250, remainder=0, div_by_zero=0.
- dividend=1234, divisor=7 -> quotient=176, remainder=2. Also dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=65535, divisor=1 -> quotient=65535, remainder=0. Also dividend=65535, divisor=255 -> quotient=257, remainder=0; exercises the 3D=765 compare path.
- dividend=17, divisor=0 -> done one cycle after start, div_by_zero=1, quotient=16'hFFFF, remainder=17. A following 100/10 command -> quotient=10, remainder=0, div_by_zero=0.
- Start 1234/7, then pulse start with 9/3 at cycle 3 -> second start ignored; result is 176 r 2. Then assert rst at cycle 4 of a new 1000/3 operation -> outputs return to 0 immediately and no done pulse occurs.
- Random sweep (at least 10k pairs, divisor != 0) -> quotient*divisor + remainder == dividend and remainder < divisor. Use products from the multiplier model as dividends to check that the multiplicand is recovered exactly.

Source files
------------

// File: rtl/radix4_seq_divider.sv
// Sequential unsigned divider retiring two quotient bits per clock by
// comparing a shifted partial remainder against precomputed 0/D/2D/3D.
module radix4_seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int RW = VW + 2;
  localparam int CW = $clog2(DW / 2 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic [RW-1:0] d1_q, d2_q, d3_q;
  logic [CW-1:0] count_q;
  logic          busy_q, done_q, dbz_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;

  logic [RW-1:0] divExt, div2, div3;
  logic [RW-1:0] trial;
  logic [VW-1:0] remNext;
  logic [1:0]    digit;
  logic [DW-1:0] quotNext;

  always_comb begin
    divExt = RW'(divisor);
    div2   = divExt << 1;
    div3   = div2 + divExt;
  end

  // Since R < D, each trial value is below 4D, so the largest fitting multiple
  // is the digit and the difference always fits back into VW bits.
  always_comb begin
    trial   = {rem_q, shift_q[DW-1 -: 2]};
    digit   = 2'd0;
    remNext = VW'(trial);
    if (trial >= d3_q) begin
      digit   = 2'd3;
      remNext = VW'(trial - d3_q);
    end else if (trial >= d2_q) begin
      digit   = 2'd2;
      remNext = VW'(trial - d2_q);
    end else if (trial >= d1_q) begin
      digit   = 2'd1;
      remNext = VW'(trial - d1_q);
    end
    quotNext = (quot_q << 2) | DW'(digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= dividend;
            quot_q  <= '0;
            rem_q   <= '0;
            d1_q    <= divExt;
            d2_q    <= div2;
            d3_q    <= div3;
            count_q <= CW'(DW / 2);
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            // A zero divisor skips the iteration and reports the saturated result.
            if (divisor == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= VW'(dividend);
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q   <= remNext;
          quot_q  <= quotNext;
          shift_q <= shift_q << 2;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quotNext;
            remainder_q <= remNext;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
